libnet_rx_seq: RTL and testbench

- Per-app receive-side sequence checker in libnet; sits upstream of the sysnet acknowledgment queue.
- Consumes 512-bit AXI-S packets from sysnet RX and checks the Lego header sequence number against the expected value.
- Forwards in-order packets to the app and drops all others.
- Drives seq_out/seq_valid, which connect directly to one app's seqN_in/seqN_valid on the ack queue.

---
 rtl/libnet_rx_seq_pkg.sv | 32 +++
 rtl/libnet_rx_seq_if.sv | 13 +
 rtl/libnet_rx_seq_axis_reg.sv | 45 ++++
 rtl/libnet_rx_seq.sv | 139 +++++++++++++
 tb/tb_libnet_rx_seq.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/libnet_rx_seq_pkg.sv
// Shared constants, state and header-class types for the libnet receive sequence checker.
// Lego header offsets assume the 512-bit first beat layout.
package libnet_pkg;

    localparam int SEQ_W          = 32;
    localparam int APPID_W        = 8;
    localparam int LEGO_APPID_LSB = 336;
    localparam int LEGO_SEQ_LSB   = 344;
    localparam int LEGO_ACK_BIT   = 376;
    localparam int LEGO_SYN_BIT   = 377;

    typedef enum logic [1:0] {HDR, PASS, DROP} rx_state_e;

    typedef enum logic [1:0] {CLS_OK, CLS_DUP, CLS_OOO, CLS_REJECT} hdr_class_e;

    // Serial-number style comparison: a negative distance means a duplicate.
    function automatic hdr_class_e classify(input logic             app_ok,
                                            input logic             ack,
                                            input logic [SEQ_W-1:0] seq,
                                            input logic [SEQ_W-1:0] exp_seq);
        logic [SEQ_W-1:0] diff;
        diff = seq - exp_seq;
        if (!app_ok || ack)
            return CLS_REJECT;
        else if (diff == '0)
            return CLS_OK;
        else if (diff[SEQ_W-1])
            return CLS_DUP;
        return CLS_OOO;
    endfunction

endpackage

// File: rtl/libnet_rx_seq_if.sv
// AXI-Stream bundle used for the sysnet RX input and the app-facing output.
interface libnet_rx_seq_if #(
    parameter int DATA_W = 512
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic                tvalid;
    logic                tlast;
    logic                tready;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tkeep, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/libnet_rx_seq_axis_reg.sv
// One-stage AXI-Stream register slice; output holds while valid and not ready.
module libnet_axis_reg #(
    parameter int DATA_W = 512
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   s_tdata_i,
    input  logic [DATA_W/8-1:0] s_tkeep_i,
    input  logic                s_tvalid_i,
    input  logic                s_tlast_i,
    output logic                s_tready_o,
    output logic [DATA_W-1:0]   m_tdata_o,
    output logic [DATA_W/8-1:0] m_tkeep_o,
    output logic                m_tvalid_o,
    output logic                m_tlast_o,
    input  logic                m_tready_i
);
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W/8-1:0] keep_q;
    logic                valid_q;
    logic                last_q;

    assign s_tready_o = !valid_q || m_tready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            keep_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (s_tvalid_i && s_tready_o) begin
            data_q  <= s_tdata_i;
            keep_q  <= s_tkeep_i;
            valid_q <= 1'b1;
            last_q  <= s_tlast_i;
        end else if (m_tready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign m_tdata_o  = data_q;
    assign m_tkeep_o  = keep_q;
    assign m_tvalid_o = valid_q;
    assign m_tlast_o  = last_q;
endmodule

// File: rtl/libnet_rx_seq.sv
// Per-app RX sequence checker: forwards in-order Lego packets, drops the rest, drives ack seq.
// Optional saturating stat counters are built when LIBNET_SEQ_STATS_EN is defined.
module libnet_rx_seq
    import libnet_pkg::*;
#(
    parameter logic [7:0] APP_ID = 8'h00,
    parameter int         DATA_W = 512
) (
    input  logic              clk,
    input  logic              rst,
    libnet_rx_seq_if.slave    rx,
    libnet_rx_seq_if.master   m,
    output logic [SEQ_W-1:0]  seq_out,
    output logic              seq_valid,
    output logic [31:0]       stat_ok,
    output logic [31:0]       stat_dup,
    output logic [31:0]       stat_ooo
);
    rx_state_e        state_q, state_d;
    logic [SEQ_W-1:0] expected_q, expected_d;
    logic [SEQ_W-1:0] seq_out_q, seq_out_d;
    logic             seq_valid_q, seq_valid_d;
    logic             slice_valid, slice_ready;
    logic             rx_ready, rx_fire;
    logic             completion, dup_hit;
    hdr_class_e       hdr_class;

    assign hdr_class = classify(rx.tdata[LEGO_APPID_LSB +: APPID_W] == APP_ID,
                                rx.tdata[LEGO_ACK_BIT],
                                rx.tdata[LEGO_SEQ_LSB +: SEQ_W],
                                expected_q);

    // Dropped beats are sunk regardless of the app; ready is forced low during reset.
    assign rx_ready  = ((state_q == DROP) || slice_ready) && !rst;
    assign rx.tready = rx_ready;
    assign rx_fire   = rx.tvalid && rx_ready;

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        seq_out_d   = seq_out_q;
        seq_valid_d = 1'b0;
        slice_valid = 1'b0;
        completion  = 1'b0;
        dup_hit     = 1'b0;
        case (state_q)
            HDR: begin
                slice_valid = rx.tvalid && (hdr_class == CLS_OK);
                if (rx_fire) begin
                    if (hdr_class == CLS_OK) begin
                        if (rx.tlast) completion = 1'b1;
                        else          state_d    = PASS;
                    end else begin
                        dup_hit = (hdr_class == CLS_DUP);
                        if (!rx.tlast) state_d = DROP;
                    end
                end
            end
            PASS: begin
                slice_valid = rx.tvalid;
                if (rx_fire && rx.tlast) begin
                    completion = 1'b1;
                    state_d    = HDR;
                end
            end
            DROP: begin
                if (rx_fire && rx.tlast) state_d = HDR;
            end
            default: state_d = HDR;
        endcase
        if (completion) begin
            expected_d  = expected_q + 1'b1;
            seq_out_d   = expected_q + 1'b1;
            seq_valid_d = 1'b1;
        end else if (dup_hit) begin
            seq_out_d   = expected_q;
            seq_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HDR;
            expected_q  <= '0;
            seq_out_q   <= '0;
            seq_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            seq_out_q   <= seq_out_d;
            seq_valid_q <= seq_valid_d;
        end
    end

    assign seq_out   = seq_out_q;
    assign seq_valid = seq_valid_q;

    libnet_axis_reg #(.DATA_W(DATA_W)) u_out_slice (
        .clk        (clk),
        .rst        (rst),
        .s_tdata_i  (rx.tdata),
        .s_tkeep_i  (rx.tkeep),
        .s_tvalid_i (slice_valid),
        .s_tlast_i  (rx.tlast),
        .s_tready_o (slice_ready),
        .m_tdata_o  (m.tdata),
        .m_tkeep_o  (m.tkeep),
        .m_tvalid_o (m.tvalid),
        .m_tlast_o  (m.tlast),
        .m_tready_i (m.tready)
    );

`ifdef LIBNET_SEQ_STATS_EN
    logic        ooo_hit;
    logic [31:0] stat_ok_q, stat_dup_q, stat_ooo_q;

    assign ooo_hit = (state_q == HDR) && rx_fire && (hdr_class == CLS_OOO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ok_q  <= '0;
            stat_dup_q <= '0;
            stat_ooo_q <= '0;
        end else begin
            if (completion && (stat_ok_q  != '1)) stat_ok_q  <= stat_ok_q  + 1'b1;
            if (dup_hit    && (stat_dup_q != '1)) stat_dup_q <= stat_dup_q + 1'b1;
            if (ooo_hit    && (stat_ooo_q != '1)) stat_ooo_q <= stat_ooo_q + 1'b1;
        end
    end

    assign stat_ok  = stat_ok_q;
    assign stat_dup = stat_dup_q;
    assign stat_ooo = stat_ooo_q;
`else
    assign stat_ok  = '0;
    assign stat_dup = '0;
    assign stat_ooo = '0;
`endif
endmodule

// File: tb/tb_libnet_rx_seq.sv
// Directed, table-driven bench for libnet_rx_seq with hand-written wrap and reset sequences.
module tb_libnet_rx_seq;
    localparam int DW = 512;
    localparam int KW = DW / 8;

    typedef struct {
        string       name;
        logic [7:0]  app;
        logic [31:0] seq;
        logic        ack;
        int          nbeats;
        logic        toggle;
        logic        exp_fwd;
        int          exp_pulses;
        logic [31:0] exp_seq_out;
        int          kind;      // 0 none, 1 ok, 2 dup, 3 ooo
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] seq_out;
    logic        seq_valid;
    logic [31:0] stat_ok, stat_dup, stat_ooo;

    libnet_rx_seq_if #(.DATA_W(DW)) rx_if ();
    libnet_rx_seq_if #(.DATA_W(DW)) m_if ();

    libnet_rx_seq #(.APP_ID(8'h00), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx_if),
        .m         (m_if),
        .seq_out   (seq_out),
        .seq_valid (seq_valid),
        .stat_ok   (stat_ok),
        .stat_dup  (stat_dup),
        .stat_ooo  (stat_ooo)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_ok = 0, exp_dup = 0, exp_ooo = 0;
    logic        toggle_en = 1'b0;
    beat_t       rcv_q[$];
    beat_t       exp_q[$];
    int          pulse_cnt = 0;
    logic [31:0] last_seq_out = '0;
    vec_t        vecs[11];

    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_if.tready = toggle_en ? ~m_if.tready : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (m_if.tvalid && m_if.tready)
                rcv_q.push_back('{m_if.tdata, m_if.tkeep, m_if.tlast});
            if (seq_valid) begin
                pulse_cnt++;
                last_seq_out = seq_out;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [7:0] app, input logic [31:0] seq,
                                input logic ack, input int nbeats, input logic toggle,
                                input logic fwd, input int pulses, input logic [31:0] so, input int kind);
        vec_t v;
        v.name = name; v.app = app; v.seq = seq; v.ack = ack; v.nbeats = nbeats;
        v.toggle = toggle; v.exp_fwd = fwd; v.exp_pulses = pulses; v.exp_seq_out = so; v.kind = kind;
        return v;
    endfunction

    function automatic beat_t make_beat(input vec_t v, input int idx);
        beat_t b;
        b.data = '0;
        if (idx == 0) begin
            b.data[47:0]    = 48'h0200_0000_0001;
            b.data[95:48]   = 48'h0200_0000_0002;
            b.data[111:96]  = 16'h0800;
            b.data[343:336] = v.app;
            b.data[375:344] = v.seq;
            b.data[376]     = v.ack;
            b.data[377]     = v.seq[0];
            b.data[511:400] = {28{4'hC}};
        end else begin
            for (int w = 0; w < 16; w++)
                b.data[w*32 +: 32] = {8'hB0 + idx[7:0], 8'(w), v.seq[15:0]};
        end
        b.last = (idx == v.nbeats - 1);
        b.keep = b.last ? {{(KW-48){1'b0}}, {48{1'b1}}} : {KW{1'b1}};
        return b;
    endfunction

    task automatic drive_beat(input beat_t b, input string name, output int stalls);
        logic ok;
        stalls = 0;
        rx_if.tdata  = b.data;
        rx_if.tkeep  = b.keep;
        rx_if.tlast  = b.last;
        rx_if.tvalid = 1'b1;
        forever begin
            @(negedge clk);
            ok = rx_if.tready;
            @(posedge clk);
            #1;
            if (ok) break;
            stalls++;
            if (stalls > 50) begin
                check({name, " accept_timeout"}, 64'(stalls), 64'd0);
                break;
            end
        end
    endtask

    task automatic check_stats(input string name);
`ifdef LIBNET_SEQ_STATS_EN
        check({name, " stat_ok"},  64'(stat_ok),  64'(exp_ok));
        check({name, " stat_dup"}, 64'(stat_dup), 64'(exp_dup));
        check({name, " stat_ooo"}, 64'(stat_ooo), 64'(exp_ooo));
`else
        check({name, " stat_ok"},  64'(stat_ok),  64'd0);
        check({name, " stat_dup"}, 64'(stat_dup), 64'd0);
        check({name, " stat_ooo"}, 64'(stat_ooo), 64'd0);
`endif
    endtask

    task automatic run_entry(input vec_t v);
        beat_t b;
        int    st;
        int    stalls_total;
        int    bad;
        rcv_q.delete();
        exp_q.delete();
        pulse_cnt    = 0;
        stalls_total = 0;
        toggle_en    = v.toggle;
        for (int i = 0; i < v.nbeats; i++) begin
            b = make_beat(v, i);
            drive_beat(b, v.name, st);
            stalls_total += st;
            if (v.exp_fwd) exp_q.push_back(b);
        end
        rx_if.tvalid = 1'b0;
        if (v.nbeats == 1 && !v.toggle)
            check({v.name, " latency_tvalid"}, 64'(m_if.tvalid), 64'(v.exp_fwd));
        toggle_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check({v.name, " beats_out"}, 64'(rcv_q.size()), 64'(exp_q.size()));
        bad = 0;
        for (int i = 0; i < rcv_q.size() && i < exp_q.size(); i++)
            if (rcv_q[i].data !== exp_q[i].data || rcv_q[i].keep !== exp_q[i].keep ||
                rcv_q[i].last !== exp_q[i].last) bad++;
        check({v.name, " beat_content_errs"}, 64'(bad), 64'd0);
        check({v.name, " seq_valid_pulses"}, 64'(pulse_cnt), 64'(v.exp_pulses));
        if (v.exp_pulses > 0)
            check({v.name, " seq_out"}, 64'(last_seq_out), 64'(v.exp_seq_out));
        if (!v.exp_fwd)
            check({v.name, " drop_stalls"}, 64'(stalls_total), 64'd0);
        case (v.kind)
            1: exp_ok++;
            2: exp_dup++;
            3: exp_ooo++;
            default: ;
        endcase
        $display("[TB] %s: app=%0h seq=%0h ack=%0b beats=%0d out=%0d pulses=%0d seq_out=%0h",
                 v.name, v.app, v.seq, v.ack, v.nbeats, rcv_q.size(), pulse_cnt, last_seq_out);
    endtask

    initial begin
        vec_t  v;
        beat_t b;
        int    st;

        vecs[0]  = mk("inorder0",   8'h00, 32'd0, 1'b0, 1, 1'b0, 1'b1, 1, 32'd1, 1);
        vecs[1]  = mk("inorder1",   8'h00, 32'd1, 1'b0, 1, 1'b0, 1'b1, 1, 32'd2, 1);
        vecs[2]  = mk("inorder2",   8'h00, 32'd2, 1'b0, 1, 1'b0, 1'b1, 1, 32'd3, 1);
        vecs[3]  = mk("multi_bp",   8'h00, 32'd3, 1'b0, 4, 1'b1, 1'b1, 1, 32'd4, 1);
        vecs[4]  = mk("two_beat",   8'h00, 32'd4, 1'b0, 2, 1'b0, 1'b1, 1, 32'd5, 1);
        vecs[5]  = mk("dup_seq3",   8'h00, 32'd3, 1'b0, 1, 1'b0, 1'b0, 1, 32'd5, 2);
        vecs[6]  = mk("ooo_seq9",   8'h00, 32'd9, 1'b0, 3, 1'b0, 1'b0, 0, 32'd0, 3);
        vecs[7]  = mk("app_mism",   8'h01, 32'd5, 1'b0, 2, 1'b0, 1'b0, 0, 32'd0, 0);
        vecs[8]  = mk("ack_set",    8'h00, 32'd5, 1'b1, 2, 1'b0, 1'b0, 0, 32'd0, 0);
        vecs[9]  = mk("after_drop", 8'h00, 32'd5, 1'b0, 1, 1'b0, 1'b1, 1, 32'd6, 1);
        vecs[10] = mk("dup_minus1", 8'h00, 32'd5, 1'b0, 2, 1'b0, 1'b0, 1, 32'd6, 2);

        rst          = 1'b1;
        rx_if.tvalid = 1'b0;
        rx_if.tlast  = 1'b0;
        rx_if.tdata  = '0;
        rx_if.tkeep  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset m_tvalid",  64'(m_if.tvalid),  64'd0);
        check("reset rx_tready", 64'(rx_if.tready), 64'd0);
        check("reset seq_valid", 64'(seq_valid),    64'd0);
        check("reset seq_out",   64'(seq_out),      64'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle rx_tready", 64'(rx_if.tready), 64'd1);

        for (int i = 0; i < 11; i++) run_entry(vecs[i]);
        check_stats("table");

        // Jump the expected counter to the wrap point rather than stepping 2^32 packets.
        force dut.expected_q = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.expected_q;
        run_entry(mk("wrap_fwd", 8'h00, 32'hFFFF_FFFF, 1'b0, 1, 1'b0, 1'b1, 1, 32'd0, 1));
        run_entry(mk("wrap_dup", 8'h00, 32'hFFFF_FFFE, 1'b0, 1, 1'b0, 1'b0, 1, 32'd0, 2));
        run_entry(mk("post_wrap0", 8'h00, 32'd0, 1'b0, 1, 1'b0, 1'b1, 1, 32'd1, 1));
        run_entry(mk("post_wrap1", 8'h00, 32'd1, 1'b0, 1, 1'b0, 1'b1, 1, 32'd2, 1));
        check_stats("wrap");

        v = mk("rst_mid", 8'h00, 32'd2, 1'b0, 3, 1'b0, 1'b1, 0, 32'd0, 0);
        for (int i = 0; i < 2; i++) begin
            b = make_beat(v, i);
            drive_beat(b, v.name, st);
        end
        b = make_beat(v, 2);
        rx_if.tdata = b.data;
        rx_if.tkeep = b.keep;
        rx_if.tlast = b.last;
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid m_tvalid",  64'(m_if.tvalid),  64'd0);
        check("rst_mid rx_tready", 64'(rx_if.tready), 64'd0);
        check("rst_mid seq_valid", 64'(seq_valid),    64'd0);
        check("rst_mid seq_out",   64'(seq_out),      64'd0);
        exp_ok = 0; exp_dup = 0; exp_ooo = 0;
        check_stats("rst_mid");
        rx_if.tvalid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("[TB] rst_mid: reset asserted during beat 2 of a 3-beat packet");
        run_entry(mk("after_rst", 8'h00, 32'd0, 1'b0, 1, 1'b0, 1'b1, 1, 32'd1, 1));
        check_stats("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule
